// File: rtl/chsel_pkg.sv
// Shared definitions for the pipelined channel selector: default sizes,
// the standard channel indices and the select-request record.
package chsel_pkg;

  localparam int DEFAULT_NUM_CH = 8;
  localparam int DEFAULT_DATA_W = 8;
  // Widest select code a request record can carry; SEL_W must not exceed it.
  localparam int SEL_MAX_W      = 8;

  typedef enum logic [2:0] {
    CH_G,
    CH_R,
    CH_B,
    CH_Y,
    CH_CR,
    CH_CB
  } ch_idx_t;

  typedef struct packed {
    logic [SEL_MAX_W-1:0] sel;
    logic                 invert;
  } sel_req_t;

endpackage

// File: rtl/chsel_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
// A DEPTH of 0 degenerates to a wire.
module chsel_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign data_out = data_in;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // NOTE: every stage is cleared on reset so in-flight beats are dropped;
      // this costs a reset net per flop but keeps valid/frame_start honest.
      always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= data_in;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign data_out = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/channel_select_pipe.sv
// Pipelined video channel selector; select changes take effect at frame start.
// Optional macro CHSEL_INVERT_EN adds an inverted-output request.
module channel_select_pipe
  import chsel_pkg::*;
#(
  parameter int              NUM_CH     = DEFAULT_NUM_CH,
  parameter int              DATA_W     = DEFAULT_DATA_W,
  parameter int              SEL_W      = $clog2(NUM_CH),
  parameter int              LATENCY    = 2,
  parameter int              RESET_SEL  = int'(CH_G),
  parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     sel_valid_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic                     valid_in,
  input  logic                     frame_start_in,
`ifdef CHSEL_INVERT_EN
  input  logic                     invert_in,
  output logic                     invert_active_out,
`endif
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic                     frame_start_out,
  output logic [SEL_W-1:0]         active_sel_out,
  output logic                     sel_pending_out
);

  localparam sel_req_t RESET_REQ = '{sel: SEL_MAX_W'(RESET_SEL), invert: 1'b0};

  sel_req_t          req;
  sel_req_t          active_q;
  sel_req_t          pending_q;
  sel_req_t          eff;
  logic              pending_valid_q;
  logic              boundary;
  logic [DATA_W-1:0] mux_data;
  logic [DATA_W-1:0] data_s1;
  logic              valid_s1;
  logic              frame_start_s1;

  assign boundary   = valid_in & frame_start_in;
  assign req.sel    = SEL_MAX_W'(sel_in);
`ifdef CHSEL_INVERT_EN
  assign req.invert = invert_in;
`else
  assign req.invert = 1'b0;
`endif

  // The boundary beat already uses the new selection, and a same-cycle
  // request bypasses the pending register entirely.
  always_comb begin
    // NOTE: default first so no path leaves eff/mux_data unassigned (no latch).
    eff = active_q;
    if (boundary) begin
      if (sel_valid_in)         eff = req;
      else if (pending_valid_q) eff = pending_q;
    end

    mux_data = FILL_VALUE;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(eff.sel) == k) mux_data = data_in[k*DATA_W +: DATA_W];
    end
    mux_data = mux_data ^ {DATA_W{eff.invert}};
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      active_q        <= RESET_REQ;
      pending_q       <= RESET_REQ;
      pending_valid_q <= 1'b0;
      data_s1         <= '0;
      valid_s1        <= 1'b0;
      frame_start_s1  <= 1'b0;
    end else begin
      if (sel_valid_in) pending_q <= req;
      if (boundary) begin
        active_q        <= eff;
        pending_valid_q <= 1'b0;
      end else if (sel_valid_in) begin
        pending_valid_q <= 1'b1;
      end
      data_s1        <= mux_data;
      valid_s1       <= valid_in;
      frame_start_s1 <= boundary;
    end
  end

  chsel_delay #(.WIDTH(DATA_W), .DEPTH(LATENCY-1)) u_data_delay (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .data_in  (data_s1),
    .data_out (data_out)
  );

  chsel_delay #(.WIDTH(1), .DEPTH(LATENCY-1)) u_valid_delay (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .data_in  (valid_s1),
    .data_out (valid_out)
  );

  chsel_delay #(.WIDTH(1), .DEPTH(LATENCY-1)) u_frame_start_delay (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .data_in  (frame_start_s1),
    .data_out (frame_start_out)
  );

  assign active_sel_out  = active_q.sel[SEL_W-1:0];
  assign sel_pending_out = pending_valid_q;
`ifdef CHSEL_INVERT_EN
  assign invert_active_out = active_q.invert;
`endif

endmodule

// File: doc/channel_select_pipe.md
Name: channel_select_pipe

Overview:
Parametrised, pipelined successor to the combinational video channel selector. Routes one of NUM_CH pixel channels (e.g. R, G, B, Y, Cr, Cb, ...) to a single output over a fixed-latency register pipeline. Selection changes are deferred to the next frame boundary so a switch-driven change never tears a frame. Sits between the colour-space conversion stage and the threshold/mask stage of the video pipeline.

Parameters:
NUM_CH, 8, number of input channels (≥2)
DATA_W, 8, bits per channel
SEL_W, $clog2(NUM_CH), width of the select code
LATENCY, 2, pipeline depth in cycles from data_in to data_out (≥1)
RESET_SEL, 0, channel active out of reset
FILL_VALUE, 0, DATA_W-bit value driven for an out-of-range select code

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  synchronous reset, active-low
sel_in  input  SEL_W  requested channel code
sel_valid_in  input  1  one-cycle strobe; sel_in is a new request
data_in  input  NUM_CH*DATA_W  flattened channels, channel k at bits [k*DATA_W +: DATA_W]
valid_in  input  1  pixel beat valid
frame_start_in  input  1  first pixel of a frame; qualified by valid_in
data_out  output  DATA_W  selected channel, registered
valid_out  output  1  valid_in delayed by LATENCY
frame_start_out  output  1  frame_start_in & valid_in delayed by LATENCY
active_sel_out  output  SEL_W  select code governing the current frame
sel_pending_out  output  1  a request is latched and not yet applied

Behaviour:
- Reset (rst_n_in low at a clock edge): data_out=0, valid_out=0, frame_start_out=0, whole pipeline cleared, active_sel_out=RESET_SEL, pending register=RESET_SEL, sel_pending_out=0. Reset mid-frame discards all in-flight beats; the request in the reset cycle is dropped.
- Request capture: sel_valid_in=1 loads pending register with sel_in and sets sel_pending_out. A later request before the boundary overwrites it (last one wins).
- Frame boundary = cycle with valid_in & frame_start_in. Then active_sel takes pending (if sel_pending_out) and sel_pending_out clears.
- Same cycle as boundary: if sel_valid_in coincides, sel_in bypasses and becomes active for the starting frame; sel_pending_out stays 0.
- Mux: the selection applied to a beat is the active select in effect for that beat (the boundary beat already uses the new selection). Code ≥ NUM_CH yields FILL_VALUE.
- Pipeline: stage 1 registers mux result; stages 2..LATENCY are plain delay. valid and frame_start are delayed identically. Fixed latency, no backpressure. Invalid beats still shift; their data_out is don't-care but deterministic (mux result of current inputs).
- No frame_start ever: requests stay pending indefinitely, active select unchanged.

Optional Feature:
CHSEL_INVERT_EN: adds ports invert_in (1) and invert_active_out (1). invert_in is captured with sel_valid_in and applied with identical pending/boundary/bypass rules. When active, stage 1 registers the bitwise inverse of the mux result (FILL_VALUE also inverted); reset value 0. Without the macro the ports do not exist and the output is never inverted.

Decomposition:
- Package chsel_pkg: the default DATA_W and NUM_CH localparams, a channel-index enum (CH_G, CH_R, CH_B, CH_Y, CH_CR, CH_CB) for the standard 6-channel build, and a sel_req_t struct {sel, invert}.
- Sub-module chsel_delay: parameterised (WIDTH, DEPTH) synchronous-reset shift register. It is instantiated for the data, valid and frame_start delay stages after stage 1.

Test Plan:
- Reset with RESET_SEL=0, NUM_CH=6, LATENCY=2; channel 0 carries 0x11, channel 1 carries 0x22 -> data_out=0x11 two cycles after the first valid_in; valid_out lags valid_in by exactly 2.
- Mid-frame sel_valid_in with sel_in=1 -> sel_pending_out=1, data_out stays 0x11 until the next frame_start beat. From that beat's output (+2 cycles) data_out=0x22 and active_sel_out=1.
- Requests sel=2 then sel=4 before a boundary -> after the boundary active_sel_out=4, and channel 2 is never seen on data_out.
- sel_valid_in=1 (sel=5) in the same cycle as frame_start_in & valid_in -> that beat's output is channel 5; sel_pending_out never asserts.
- sel_in=7 with NUM_CH=6, FILL_VALUE=0x80 -> after the boundary data_out=0x80 for every beat.
- Assert rst_n_in low for one cycle mid-frame with a pending request -> next cycle valid_out=0, sel_pending_out=0, active_sel_out=RESET_SEL. With CHSEL_INVERT_EN, an invert request plus boundary gives 0xEE for input 0x11.
